// File: rtl/motorb_relu_act_reader.sv
// motorb_relu_act_reader
// Reads a stream of ReLU activations (ap_fixed<32,8> with the sign bit
// dropped) through a small circular FIFO and restores them to 32 bits.
// A pop counter marks the last element of each N_ELEM-long layer vector
// (out_last) and pulses vec_done the cycle after that vector completes.
//
// Optional feature, enabled by defining MOTORB_RELU_ZERO_COUNT_EN:
//   adds port zero_cnt, the number of zero activations popped in the last
//   completed vector. Without the macro the port and its counter are absent.
//
// Reset is synchronous and active-high on ap_rst. It flushes the FIFO and
// the element count, so a partially delivered vector is discarded.

module motorb_relu_act_reader #(
    parameter int DEPTH  = 4,   // FIFO entries, power of two, >= 2
    parameter int N_ELEM = 16   // activations per layer vector, >= 2
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [30:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        vec_done
`ifdef MOTORB_RELU_ZERO_COUNT_EN
    ,
    output logic [$clog2(N_ELEM+1)-1:0] zero_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(N_ELEM);

    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX  = CW'(N_ELEM - 1);

    logic [30:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_next;
    logic          in_ready_q;
    logic [CW-1:0] elem_cnt;
    logic          vec_done_q;

    logic          push;
    logic          pop;
    logic          at_last;
    logic [30:0]   head_data;

    // in_ready comes only from a register, so a full FIFO drops any push even
    // when a pop happens in the same cycle; upstream already sees in_ready low.
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign head_data = mem[rd_ptr];
    assign at_last   = (elem_cnt == LAST_IDX);

    assign in_ready  = in_ready_q;
    assign out_valid = (occ != '0);
    assign out_last  = at_last & out_valid;
    assign out_data  = out_valid ? {1'b0, head_data} : 32'd0;
    assign vec_done  = vec_done_q;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_next = occ;
        unique case ({push, pop})
            2'b10:   occ_next = occ + OW'(1);
            2'b01:   occ_next = occ - OW'(1);
            default: occ_next = occ;
        endcase
    end

    // Storage array; not reset because the pointers define what is valid.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ <= occ_next;
        end
    end

    // Registered not-full flag; low during reset, high the cycle after release.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (occ_next != DEPTH_OCC);
        end
    end

    // Element position within the vector and the completion pulse.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            elem_cnt   <= '0;
            vec_done_q <= 1'b0;
        end else begin
            vec_done_q <= pop & at_last;
            if (pop) begin
                if (at_last) begin
                    elem_cnt <= '0;
                end else begin
                    elem_cnt <= elem_cnt + CW'(1);
                end
            end
        end
    end

`ifdef MOTORB_RELU_ZERO_COUNT_EN
    localparam int ZW = $clog2(N_ELEM + 1);

    logic [ZW-1:0] zero_run;
    logic [ZW-1:0] zero_cnt_q;
    logic [ZW-1:0] zero_total;
    logic          head_zero;

    assign head_zero  = (head_data == 31'd0);
    assign zero_total = zero_run + ZW'(head_zero);
    assign zero_cnt   = zero_cnt_q;

    // Running zero count; the total including the last element is published
    // on the last pop and held until the next vector completes.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            zero_run   <= '0;
            zero_cnt_q <= '0;
        end else if (pop) begin
            if (at_last) begin
                zero_cnt_q <= zero_total;
                zero_run   <= '0;
            end else begin
                zero_run   <= zero_total;
            end
        end
    end
`endif

endmodule

// File: tb/tb_motorb_relu_act_reader.sv
// Directed self-checking bench for motorb_relu_act_reader (DEPTH=4, N_ELEM=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.

module tb_motorb_relu_act_reader;

    logic        ap_clk;
    logic        ap_rst;
    logic [30:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        vec_done;
`ifdef MOTORB_RELU_ZERO_COUNT_EN
    logic [4:0]  zero_cnt;
`endif

    int checks = 0;
    int errors = 0;

    motorb_relu_act_reader #(.DEPTH(4), .N_ELEM(16)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .vec_done  (vec_done)
`ifdef MOTORB_RELU_ZERO_COUNT_EN
        ,
        .zero_cnt  (zero_cnt)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        ap_rst = 1'b0;
        tick();
    endtask

    // Streams n elements base+i with out_ready high; occupancy stays at one,
    // so after each edge the head is the element just pushed.
    task automatic stream_vec(input int n, input logic [30:0] base, input int last_at, input string tag);
        logic [30:0] v;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            v        = base + 31'(i);
            in_data  = v;
            in_valid = 1'b1;
            tick();
            chk({tag, "_data"}, out_data, {1'b0, v});
            chk({tag, "_last"}, 32'(out_last), 32'(i == last_at));
            chk({tag, "_done"}, 32'(vec_done), 32'(i == last_at + 1));
        end
        in_valid = 1'b0;
        tick();
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_done"}, 32'(vec_done), 32'(n - 1 == last_at));
    endtask

    initial begin
        logic [30:0] v;

        // Reset values
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_vec_done", 32'(vec_done), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
`ifdef MOTORB_RELU_ZERO_COUNT_EN
        chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
`endif
        ap_rst = 1'b0;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // Single element, one-cycle latency
        in_data   = 31'h1234_5678;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data", out_data, 32'h1234_5678);
        chk("one_last", 32'(out_last), 32'd0);
        tick();
        chk("one_empty", 32'(out_valid), 32'd0);

        // Fill to full with out_ready low, 5th held upstream
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            in_data  = 31'(k);
            in_valid = 1'b1;
            tick();
            chk("fill_ready", 32'(in_ready), 32'(k < 4));
        end
        in_data = 31'd5;
        tick();
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_data, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("full_pop_data", out_data, 32'd2);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("order_3", out_data, 32'd3);
        tick();
        chk("order_4", out_data, 32'd4);
        chk("order_4_last", 32'(out_last), 32'd0);
        tick();
        chk("order_5", out_data, 32'd5);
        tick();
        chk("order_empty", 32'(out_valid), 32'd0);

        // Continuous stream: last on the 16th, done one cycle later
        do_reset();
        stream_vec(17, 31'h100, 15, "strm");

        // Reset with 3 queued entries and element count at 7
        do_reset();
        stream_vec(7, 31'h300, 15, "pre");
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data  = 31'h3A0 + 31'(k);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("q3_valid", 32'(out_valid), 32'd1);
        ap_rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        ap_rst = 1'b0;
        tick();
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);
        stream_vec(17, 31'h400, 15, "post");

        // Push and pop together at occupancy 2 for 20 cycles
        do_reset();
        for (int k = 0; k < 2; k++) begin
            in_data  = 31'h4000_0200 + 31'(k);
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data  = 31'h4000_0200 + 31'(k + 2);
            in_valid = 1'b1;
            tick();
            chk("pp_data", out_data, 32'h4000_0200 + 32'(k + 1));
            chk("pp_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("pp_tail_data", out_data, 32'h4000_0215);
        chk("pp_tail_valid", 32'(out_valid), 32'd1);
        tick();
        chk("pp_tail_empty", 32'(out_valid), 32'd0);

`ifdef MOTORB_RELU_ZERO_COUNT_EN
        // Vector with zeros at 0,3,7,8,15
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = (i == 0 || i == 3 || i == 7 || i == 8 || i == 15) ? 31'd0 : 31'(i + 1);
            in_data  = v;
            in_valid = 1'b1;
            tick();
            chk("zc_before", 32'(zero_cnt), 32'd0);
        end
        for (int j = 0; j < 16; j++) begin
            in_data  = 31'h55 + 31'(j);
            in_valid = 1'b1;
            tick();
            chk("zc_held", 32'(zero_cnt), 32'd5);
        end
        in_valid = 1'b0;
        tick();
        chk("zc_next_vec", 32'(zero_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motorb_relu_act_reader.md
MOTORB_RELU_ACT_READER -- requirements
Module: motorB_relu_act_reader

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter N_ELEM, default 16, activations per layer vector (>=2).
REQ-003 SHALL provide port ap_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL provide port ap_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_data  input  31  ReLU activation, non-negative ap_fixed<32,8> with the sign bit dropped.
REQ-006 SHALL provide port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL provide port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL provide port out_data  output  32  activation restored to ap_fixed<32,8>.
REQ-009 SHALL provide port out_valid  output  1  out_data valid.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL provide port out_last  output  1  out_data is the last element of the current vector.
REQ-012 SHALL provide port vec_done  output  1  one-cycle pulse after a vector completes.
REQ-013 SHALL provide port zero_cnt  output  clog2(N_ELEM+1)  zero activations in the last completed vector (present only with ZERO_COUNT_EN).

Function
REQ-014 SHALL accept one element per cycle on every cycle where in_valid and in_ready are both high.
REQ-015 SHALL drive in_ready = not full, registered-status based, with no combinational path from out_ready.
REQ-016 SHALL drop a push while full, including a full FIFO with a simultaneous pop; in_ready is already low in that case.
REQ-017 SHALL store elements in a DEPTH-entry circular FIFO whose read and write pointers wrap modulo DEPTH.
REQ-018 SHALL push and pop in the same cycle when neither full nor empty, leaving the occupancy unchanged.
REQ-019 SHALL zero-extend on output: out_data = {1'b0, stored in_data}, with no other arithmetic.
REQ-020 SHALL assert out_valid = not empty; first-element latency SHALL be 1 cycle from accept to out_valid.
REQ-021 SHALL pop on out_valid and out_ready, and SHALL hold out_data and out_valid stable while out_ready is low.
REQ-022 SHALL count popped elements 0..N_ELEM-1; out_last SHALL equal (count == N_ELEM-1) AND out_valid.
REQ-023 SHALL wrap the element count to 0 on a pop with out_last high, and SHALL pulse vec_done high for exactly the following cycle.
REQ-024 SHALL keep vectors back-to-back: the element popped after a wrap is element 0 of the next vector, with no gap.

Reset
REQ-025 SHALL on ap_rst drive in_ready=0, out_valid=0, out_last=0, vec_done=0, out_data=0 and zero_cnt=0 during reset.
REQ-026 SHALL raise in_ready the first cycle after ap_rst deasserts.
REQ-027 SHALL on reset mid-operation flush all FIFO contents and pointers and clear the element count; partial vectors are discarded.

Configuration
REQ-028 SHALL, with macro MOTORB_RELU_ZERO_COUNT_EN defined, count popped elements with out_data == 0 in the current vector; on the out_last pop it SHALL load the total (including that element) into zero_cnt, held until the next vector completes, and SHALL restart the running count at 0.
REQ-029 SHALL, without MOTORB_RELU_ZERO_COUNT_EN, omit port zero_cnt and its counter, with all other behaviour identical.

Verification
REQ-030 Bench SHALL cover: reset, then push 0x12345678 with out_ready=1 -> out_valid next cycle, out_data=0x12345678, out_last=0.
REQ-031 Bench SHALL cover: out_ready=0 while pushing 5 elements with DEPTH=4 -> in_ready low after 4 accepts; 5th held upstream; data 1,2,3,4 emerge in order once out_ready=1.
REQ-032 Bench SHALL cover: stream 16 elements continuously, N_ELEM=16 -> out_last high only on the 16th; vec_done pulse one cycle later; the 17th element has out_last=0.
REQ-033 Bench SHALL cover: ZERO_COUNT_EN with a vector containing 5 zeros -> zero_cnt=5 the cycle after the last pop and held through the next vector.
REQ-034 Bench SHALL cover: assert ap_rst with 3 entries queued and count=7 -> out_valid=0; after release the first new element is element 0 and the next out_last comes 16 pops later.
REQ-035 Bench SHALL cover: simultaneous push/pop at occupancy 2 for 20 cycles with pointer wrap -> occupancy stays 2 and data order is preserved.
